// File: rtl/alu_top_8bit_reg_if.sv
// Operand/opcode/result bundle for alu_top_8bit_reg.
// Flag signals Z/N/V exist only when ALU_FLAGS_EN is defined.
interface alu_top_8bit_reg_if;
   logic [7:0] A;
   logic [7:0] B;
   logic [2:0] sel;
   logic [7:0] Y;
   logic       Cout;
`ifdef ALU_FLAGS_EN
   logic       Z;
   logic       N;
   logic       V;
`endif

`ifdef ALU_FLAGS_EN
   modport master (output A, B, sel, input Y, Cout, Z, N, V);
   modport slave  (input A, B, sel, output Y, Cout, Z, N, V);
`else
   modport master (output A, B, sel, input Y, Cout);
   modport slave  (input A, B, sel, output Y, Cout);
`endif
endinterface

// File: rtl/alu_top_8bit_reg.sv
// 8-bit, 8-operation ALU with registered Y/Cout (one-cycle latency).
// Optional registered Z/N/V flags are enabled by defining ALU_FLAGS_EN.
module alu_top_8bit_reg (
   input logic             clk,
   input logic             rst,
   alu_top_8bit_reg_if.slave bus
);
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SHL = 3'b100,
      OP_SRA = 3'b101,
      OP_XOR = 3'b110,
      OP_NOT = 3'b111
   } op_e;

   op_e               op;
   logic [2:0]        shamt;
   logic [8:0]        sum;
   logic [8:0]        diff;
   logic [8:0]        shl_ext;
   logic signed [8:0] sra_ext;

   logic [7:0] y_d, y_q;
   logic       cout_d, cout_q;

   // Shifts carry a guard bit so the last bit shifted out lands in a fixed
   // position (bit 8 for SHL, bit 0 for SRA) and is naturally 0 when S=0.
   always_comb begin
      op      = op_e'(bus.sel);
      shamt   = bus.B[2:0];
      sum     = {1'b0, bus.A} + {1'b0, bus.B};
      diff    = {1'b0, bus.A} + {1'b0, ~bus.B} + 9'd1;
      shl_ext = {1'b0, bus.A} << shamt;
      sra_ext = $signed({bus.A, 1'b0}) >>> shamt;

      y_d    = '0;
      cout_d = 1'b0;
      case (op)
         OP_ADD: {cout_d, y_d} = sum;
         OP_SUB: {cout_d, y_d} = diff;
         OP_AND: y_d = bus.A & bus.B;
         OP_OR:  y_d = bus.A | bus.B;
         OP_SHL: {cout_d, y_d} = shl_ext;
         OP_SRA: {y_d, cout_d} = sra_ext;
         OP_XOR: y_d = bus.A ^ bus.B;
         OP_NOT: y_d = ~bus.A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         y_q    <= y_d;
         cout_q <= cout_d;
      end
   end

   assign bus.Y    = y_q;
   assign bus.Cout = cout_q;

`ifdef ALU_FLAGS_EN
   logic z_d, z_q;
   logic n_d, n_q;
   logic v_d, v_q;

   always_comb begin
      z_d = (y_d == 8'h00);
      n_d = y_d[7];
      v_d = 1'b0;
      case (op)
         OP_ADD:  v_d = (bus.A[7] == bus.B[7]) && (sum[7] != bus.A[7]);
         OP_SUB:  v_d = (bus.A[7] != bus.B[7]) && (diff[7] != bus.A[7]);
         default: v_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z_q <= 1'b1;
         n_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         z_q <= z_d;
         n_q <= n_d;
         v_q <= v_d;
      end
   end

   assign bus.Z = z_q;
   assign bus.N = n_q;
   assign bus.V = v_q;
`endif
endmodule

// File: tb/tb_alu_top_8bit_reg.sv
// Self-checking bench for alu_top_8bit_reg: directed vector table plus a
// randomized back-to-back stream with a mid-stream reset pulse.
module tb_alu_top_8bit_reg;
   logic clk = 1'b0;
   logic rst;

   alu_top_8bit_reg_if bus ();

   alu_top_8bit_reg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] sel;
      logic [7:0] y;
      logic       cout;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] y;
      logic       cout;
      logic       z;
      logic       n;
      logic       v;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Independent reference: shifts done bit by bit, overflow via integer range.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] sel);
      logic [7:0] y;
      logic       c;
      logic       v;
      int         sa, sb2, r;
      y = 8'h00; c = 1'b0; v = 1'b0;
      sa = int'($signed(a)); sb2 = int'($signed(b));
      case (sel)
         3'd0: begin
            r = int'(a) + int'(b);
            y = r[7:0]; c = (r > 255);
            v = ((sa + sb2) > 127) || ((sa + sb2) < -128);
         end
         3'd1: begin
            r = int'(a) - int'(b);
            y = r[7:0]; c = (a >= b);
            v = ((sa - sb2) > 127) || ((sa - sb2) < -128);
         end
         3'd2: y = a & b;
         3'd3: y = a | b;
         3'd4: begin
            y = a;
            for (int i = 0; i < int'(b[2:0]); i++) begin
               c = y[7]; y = {y[6:0], 1'b0};
            end
         end
         3'd5: begin
            y = a;
            for (int i = 0; i < int'(b[2:0]); i++) begin
               c = y[0]; y = {y[7], y[7:1]};
            end
         end
         3'd6: y = a ^ b;
         default: y = ~a;
      endcase
      return {v, c, y};
   endfunction

   // Drive one cycle of stimulus, push its expectation, then check after the edge.
   task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sel, input logic [7:0] ey, input logic ec,
                       input logic ev, input string name);
      exp_t e;
      rst = r; bus.A = a; bus.B = b; bus.sel = sel;
      e.y = ey; e.cout = ec; e.z = (ey == 8'h00); e.n = ey[7]; e.v = ev; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests++;
      if (bus.Y !== e.y || bus.Cout !== e.cout) begin
         fails++;
         $display("FAIL %s: got Y=%h Cout=%b, expected Y=%h Cout=%b",
                  e.name, bus.Y, bus.Cout, e.y, e.cout);
      end
`ifdef ALU_FLAGS_EN
      tests++;
      if (bus.Z !== e.z || bus.N !== e.n || bus.V !== e.v) begin
         fails++;
         $display("FAIL %s flags: got ZNV=%b%b%b, expected ZNV=%b%b%b",
                  e.name, bus.Z, bus.N, bus.V, e.z, e.n, e.v);
      end
`endif
   endtask

   vec_t tbl[16];

   initial begin
      logic [9:0]  m;
      logic [7:0]  ra, rb;
      logic [2:0]  rs;

      tbl[0]  = '{8'h05, 8'h03, 3'b000, 8'h08, 1'b0, "add_5_3"};
      tbl[1]  = '{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, "add_wrap"};
      tbl[2]  = '{8'h05, 8'h03, 3'b001, 8'h02, 1'b1, "sub_5_3"};
      tbl[3]  = '{8'h03, 8'h05, 3'b001, 8'hFE, 1'b0, "sub_borrow"};
      tbl[4]  = '{8'hCC, 8'hAA, 3'b010, 8'h88, 1'b0, "and"};
      tbl[5]  = '{8'hCC, 8'hAA, 3'b011, 8'hEE, 1'b0, "or"};
      tbl[6]  = '{8'hCC, 8'hAA, 3'b110, 8'h66, 1'b0, "xor"};
      tbl[7]  = '{8'hCC, 8'hAA, 3'b111, 8'h33, 1'b0, "not"};
      tbl[8]  = '{8'h0F, 8'h02, 3'b100, 8'h3C, 1'b0, "shl_2"};
      tbl[9]  = '{8'hF0, 8'h03, 3'b101, 8'hFE, 1'b0, "sra_3"};
      tbl[10] = '{8'h81, 8'h01, 3'b101, 8'hC0, 1'b1, "sra_1"};
      tbl[11] = '{8'h0F, 8'h0A, 3'b100, 8'h3C, 1'b0, "shl_b_high_ignored"};
      tbl[12] = '{8'h81, 8'h01, 3'b100, 8'h02, 1'b1, "shl_cout"};
      tbl[13] = '{8'hA5, 8'h00, 3'b100, 8'hA5, 1'b0, "shl_0"};
      tbl[14] = '{8'h7F, 8'h07, 3'b101, 8'h00, 1'b1, "sra_7"};
      tbl[15] = '{8'h80, 8'h01, 3'b001, 8'h7F, 1'b1, "sub_ovf"};

      rst = 1'b1; bus.A = 8'hFF; bus.B = 8'h01; bus.sel = 3'b000;
      @(posedge clk);
      step(1'b1, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b0, 1'b0, "reset_1");
      step(1'b1, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b0, 1'b0, "reset_2");

      foreach (tbl[i]) begin
         m = model(tbl[i].a, tbl[i].b, tbl[i].sel);
         step(1'b0, tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].y, tbl[i].cout, m[9], tbl[i].name);
      end

      // Back-to-back random stream; one-cycle reset pulse must blank exactly one result.
      for (int i = 0; i < 60; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 3'($urandom_range(0, 7));
         if (i == 30) begin
            step(1'b1, ra, rb, rs, 8'h00, 1'b0, 1'b0, "stream_reset_pulse");
         end else begin
            m = model(ra, rb, rs);
            step(1'b0, ra, rb, rs, m[7:0], m[8], m[9], "stream");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
